// File: rtl/wait_queue_pkg.sv
// -----------------------------------------------------------------------------
// wait_queue_pkg
// Shared types and constants for the service-hall wait-queue scheduler:
//   - sched_state_t : dispatch FSM states (IDLE, GRANT, HOLD)
//   - TICKET_W      : ticket number width
//   - WAIT_W        : per-ticket wait counter width (minutes)
//   - WAIT_MAX      : saturation value of the wait counter
//   - entry_t       : one queue slot {ticket, age}
//   - age_inc()     : saturating minute increment
// -----------------------------------------------------------------------------
package wait_queue_pkg;

    localparam int TICKET_W = 8;
    localparam int WAIT_W   = 16;
    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [TICKET_W-1:0] ticket;
        logic [WAIT_W-1:0]   age;
    } entry_t;

    // Minute ageing sticks at WAIT_MAX instead of wrapping back to zero.
    function automatic logic [WAIT_W-1:0] age_inc(input logic [WAIT_W-1:0] age);
        return (age == WAIT_MAX) ? age : age + 1'b1;
    endfunction

endpackage

// File: rtl/wait_fifo.sv
// -----------------------------------------------------------------------------
// wait_fifo
// DEPTH-entry FIFO of {ticket, age}. A global age strobe increments the age of
// every slot (saturating); a slot written on the same cycle starts at zero.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset (flushes the queue)
//   push         in   write push_ticket at the tail (caller guarantees room,
//                     or a simultaneous pop when full)
//   push_ticket  in   ticket number to store
//   pop          in   drop the head entry
//   age_tick     in   minute boundary: age every slot by one
//   head         out  current head entry (valid when !empty)
//   count        out  number of occupied entries
//   full         out  count == DEPTH
//   empty        out  count == 0
// -----------------------------------------------------------------------------
module wait_fifo
    import wait_queue_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic [TICKET_W-1:0] push_ticket,
    input  logic                pop,
    input  logic                age_tick,
    output entry_t              head,
    output logic [CNT_W-1:0]    count,
    output logic                full,
    output logic                empty
);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    entry_t           mem      [DEPTH];
    entry_t           mem_next [DEPTH];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Ageing every slot is harmless for empty ones: a push always overwrites
    // the age with zero, so stale values never become visible.
    // NOTE: each element is defaulted to its current value before any
    // conditional update, so no path leaves mem_next unassigned (no latch).
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_next[i] = mem[i];
            if (age_tick) mem_next[i].age = age_inc(mem[i].age);
        end
        if (push) begin
            mem_next[wr_ptr].ticket = push_ticket;
            mem_next[wr_ptr].age    = '0;
        end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by the
    // pointers and count, and a slot is always written before it is read.
    always_ff @(posedge clk) begin
        mem <= mem_next;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/wait_queue_sched.sv
// -----------------------------------------------------------------------------
// wait_queue_sched
// Customer-queue scheduler: issues ticket numbers on arrival, holds waiting
// tickets in a FIFO, ages them in whole minutes from a 1 Hz tick and
// dispatches the oldest ticket to a free service window by round-robin.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   sec_tick      in   one-cycle pulse per second
//   arrive        in   one-cycle pulse, new customer
//   win_free      in   [NUM_WIN] level, window idle (sampled in IDLE only)
//   accept        out  pulse, cycle after arrive: ticket enqueued
//   reject        out  pulse, cycle after arrive: queue full, dropped
//   grant_valid   out  pulse: dispatch this cycle
//   grant_win     out  [3]  window index of the latest grant
//   grant_ticket  out  [8]  ticket dispatched (0 when !grant_valid)
//   grant_wait    out  [16] minutes that ticket waited (0 when !grant_valid)
//   queue_len     out  entries waiting
//   full          out  queue_len == DEPTH
// -----------------------------------------------------------------------------
module wait_queue_sched
    import wait_queue_pkg::*;
#(
    parameter  int NUM_WIN     = 2,
    parameter  int DEPTH       = 8,
    parameter  int SEC_PER_MIN = 60,
    localparam int LEN_W       = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sec_tick,
    input  logic                arrive,
    input  logic [NUM_WIN-1:0]  win_free,
    output logic                accept,
    output logic                reject,
    output logic                grant_valid,
    output logic [2:0]          grant_win,
    output logic [TICKET_W-1:0] grant_ticket,
    output logic [WAIT_W-1:0]   grant_wait,
    output logic [LEN_W-1:0]    queue_len,
    output logic                full
);

    localparam int SEC_W = (SEC_PER_MIN > 1) ? $clog2(SEC_PER_MIN) : 1;

    sched_state_t        state;
    sched_state_t        state_next;
    logic                load_grant;
    logic [SEC_W-1:0]    sec_cnt;
    logic                minute_tick;
    logic [TICKET_W-1:0] ticket_cnt;
    logic [2:0]          rr_ptr;
    logic [2:0]          pick;
    logic [2:0]          pick_next_rr;
    logic                pick_found;
    logic                push;
    logic                pop;
    logic                empty;
    entry_t              head;

    // The head leaves the queue on the last edge of the GRANT cycle, so an
    // arrival in that cycle still fits into a full queue.
    assign pop         = (state == GRANT);
    assign push        = arrive && (!full || pop);
    assign minute_tick = sec_tick && (sec_cnt == SEC_W'(SEC_PER_MIN - 1));

    wait_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_ticket (ticket_cnt),
        .pop         (pop),
        .age_tick    (minute_tick),
        .head        (head),
        .count       (queue_len),
        .full        (full),
        .empty       (empty)
    );

    // Seconds within the current minute.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sec_cnt <= '0;
        end else if (sec_tick) begin
            sec_cnt <= minute_tick ? '0 : sec_cnt + 1'b1;
        end
    end

    // Ticket issue and the registered accept/reject answer to an arrival.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ticket_cnt <= '0;
            accept     <= 1'b0;
            reject     <= 1'b0;
        end else begin
            accept <= push;
            reject <= arrive && !push;
            if (push) ticket_cnt <= ticket_cnt + 1'b1;
        end
    end

    // Round-robin pick: first free window at or above rr_ptr, otherwise the
    // lowest free window (the wrap-around half of the circular search).
    always_comb begin
        pick_found = 1'b0;
        pick       = '0;
        for (int w = 0; w < NUM_WIN; w++) begin
            if (!pick_found && win_free[w] && (3'(w) >= rr_ptr)) begin
                pick_found = 1'b1;
                pick       = 3'(w);
            end
        end
        for (int w = 0; w < NUM_WIN; w++) begin
            if (!pick_found && win_free[w]) begin
                pick_found = 1'b1;
                pick       = 3'(w);
            end
        end
        pick_next_rr = (pick == 3'(NUM_WIN - 1)) ? 3'd0 : pick + 3'd1;
    end

    // Dispatch FSM. win_free is only looked at in IDLE; HOLD gives the granted
    // window one cycle to drop its free flag before it is sampled again.
    always_comb begin
        state_next = state;
        load_grant = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && pick_found) begin
                    state_next = GRANT;
                    load_grant = 1'b1;
                end
            end
            GRANT:   state_next = HOLD;
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            grant_win <= '0;
            rr_ptr    <= '0;
        end else begin
            state <= state_next;
            if (load_grant) begin
                grant_win <= pick;
                rr_ptr    <= pick_next_rr;
            end
        end
    end

    // During GRANT the head is the entry being popped; its age is still the
    // pre-increment value if this cycle is also a minute boundary.
    assign grant_valid  = pop;
    assign grant_ticket = pop ? head.ticket : '0;
    assign grant_wait   = pop ? head.age    : '0;

endmodule

// File: tb/tb_wait_queue_sched.sv
// -----------------------------------------------------------------------------
// tb_wait_queue_sched
// Directed bench for wait_queue_sched. u_dut runs the default 60-tick minute;
// u_dut_fast uses a one-tick minute so minute ageing and saturation can be
// exercised in a reasonable number of cycles. Inputs change on the falling
// edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_wait_queue_sched;

    logic        clk = 1'b0;
    logic        reset;

    logic        sec_tick, arrive;
    logic [1:0]  win_free;
    logic        accept, reject, grant_valid, full;
    logic [2:0]  grant_win;
    logic [7:0]  grant_ticket;
    logic [15:0] grant_wait;
    logic [3:0]  queue_len;

    logic        f_sec_tick, f_arrive;
    logic [1:0]  f_win_free;
    logic        f_accept, f_reject, f_grant_valid, f_full;
    logic [2:0]  f_grant_win;
    logic [7:0]  f_grant_ticket;
    logic [15:0] f_grant_wait;
    logic [3:0]  f_queue_len;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wait_queue_sched #(.NUM_WIN(2), .DEPTH(8), .SEC_PER_MIN(60)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .sec_tick     (sec_tick),
        .arrive       (arrive),
        .win_free     (win_free),
        .accept       (accept),
        .reject       (reject),
        .grant_valid  (grant_valid),
        .grant_win    (grant_win),
        .grant_ticket (grant_ticket),
        .grant_wait   (grant_wait),
        .queue_len    (queue_len),
        .full         (full)
    );

    wait_queue_sched #(.NUM_WIN(2), .DEPTH(8), .SEC_PER_MIN(1)) u_dut_fast (
        .clk          (clk),
        .reset        (reset),
        .sec_tick     (f_sec_tick),
        .arrive       (f_arrive),
        .win_free     (f_win_free),
        .accept       (f_accept),
        .reject       (f_reject),
        .grant_valid  (f_grant_valid),
        .grant_win    (f_grant_win),
        .grant_ticket (f_grant_ticket),
        .grant_wait   (f_grant_wait),
        .queue_len    (f_queue_len),
        .full         (f_full)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        reset      = 1'b0;
        sec_tick   = 1'b0;
        arrive     = 1'b0;
        win_free   = 2'b00;
        f_sec_tick = 1'b0;
        f_arrive   = 1'b0;
        f_win_free = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Wait on falling edges for a grant pulse; cyc is the number of falling
    // edges it took, or -1 if the budget ran out (reported as a failure).
    task automatic wait_grant(input bit fast, input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if ((fast ? f_grant_valid : grant_valid) == 1'b1) begin
                cyc = i;
                break;
            end
        end
        if (cyc < 0) check(fast ? "fast grant seen" : "grant seen",
                           32'(fast ? f_grant_valid : grant_valid), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cyc;

        // ---------------- reset state ----------------
        apply_reset();
        check("rst accept",       32'(accept),       0);
        check("rst reject",       32'(reject),       0);
        check("rst grant_valid",  32'(grant_valid),  0);
        check("rst grant_win",    32'(grant_win),    0);
        check("rst grant_ticket", 32'(grant_ticket), 0);
        check("rst grant_wait",   32'(grant_wait),   0);
        check("rst queue_len",    32'(queue_len),    0);
        check("rst full",         32'(full),         0);

        // ---------------- three arrivals, one window ----------------
        win_free = 2'b01;
        arrive   = 1'b1;
        @(negedge clk);
        check("t1 accept",    32'(accept),    1);
        check("t1 queue_len", 32'(queue_len), 1);
        @(negedge clk);
        check("t1 latency grant_valid", 32'(grant_valid),  1);
        check("t1 g0 ticket",           32'(grant_ticket), 0);
        check("t1 g0 win",              32'(grant_win),    0);
        check("t1 g0 wait",             32'(grant_wait),   0);
        @(posedge clk);
        #1 arrive = 1'b0;
        wait_grant(0, 6, cyc);
        check("t1 g1 spacing", 32'(cyc),          3);
        check("t1 g1 ticket",  32'(grant_ticket), 1);
        check("t1 g1 win",     32'(grant_win),    0);
        wait_grant(0, 6, cyc);
        check("t1 g2 spacing", 32'(cyc),          3);
        check("t1 g2 ticket",  32'(grant_ticket), 2);
        check("t1 g2 win",     32'(grant_win),    0);
        check("t1 g2 wait",    32'(grant_wait),   0);
        repeat (3) @(negedge clk);
        check("t1 drained queue_len", 32'(queue_len), 0);

        // ---------------- two minutes of waiting, round-robin ----------------
        apply_reset();
        arrive = 1'b1;
        @(negedge clk);
        arrive = 1'b0;
        check("t2 accept", 32'(accept), 1);
        for (int k = 0; k < 120; k++) begin
            sec_tick = 1'b1;
            @(negedge clk);
            sec_tick = 1'b0;
            @(negedge clk);
        end
        check("t2 no grant while busy", 32'(grant_valid), 0);
        win_free = 2'b11;
        wait_grant(0, 6, cyc);
        check("t2 ticket", 32'(grant_ticket), 0);
        check("t2 win",    32'(grant_win),    0);
        check("t2 wait",   32'(grant_wait),   2);
        win_free = 2'b10;
        arrive   = 1'b1;
        @(negedge clk);
        arrive = 1'b0;
        wait_grant(0, 8, cyc);
        check("t2 rr ticket", 32'(grant_ticket), 1);
        check("t2 rr win",    32'(grant_win),    1);
        check("t2 rr wait",   32'(grant_wait),   0);

        // ---------------- full queue, reject, accept on pop ----------------
        apply_reset();
        arrive = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("t3 fill accept",    32'(accept),    1);
            check("t3 fill queue_len", 32'(queue_len), 32'(i));
        end
        @(negedge clk);
        arrive = 1'b0;
        check("t3 reject",           32'(reject),    1);
        check("t3 no accept",        32'(accept),    0);
        check("t3 full",             32'(full),      1);
        check("t3 queue_len at max", 32'(queue_len), 8);
        win_free = 2'b01;
        wait_grant(0, 6, cyc);
        arrive = 1'b1;
        check("t3 pop ticket", 32'(grant_ticket), 0);
        @(negedge clk);
        arrive = 1'b0;
        check("t3 accept on pop",    32'(accept),    1);
        check("t3 reject on pop",    32'(reject),    0);
        check("t3 queue_len on pop", 32'(queue_len), 8);
        check("t3 full on pop",      32'(full),      1);
        for (int k = 1; k <= 8; k++) begin
            wait_grant(0, 8, cyc);
            check("t3 drain ticket", 32'(grant_ticket), 32'(k));
        end
        repeat (2) @(negedge clk);
        check("t3 drained queue_len", 32'(queue_len), 0);
        check("t3 drained full",      32'(full),      0);

        // ---------------- ticket counter wrap ----------------
        apply_reset();
        win_free = 2'b01;
        for (int i = 0; i <= 256; i++) begin
            arrive = 1'b1;
            @(negedge clk);
            arrive = 1'b0;
            wait_grant(0, 6, cyc);
            check("t4 ticket sequence", 32'(grant_ticket), 32'(i % 256));
        end

        // ---------------- minute ageing on the fast instance ----------------
        // Arrival on a minute boundary starts at 0; the next boundary makes it
        // 1, and the boundary during GRANT does not show in grant_wait.
        apply_reset();
        f_win_free = 2'b01;
        f_sec_tick = 1'b1;
        f_arrive   = 1'b1;
        @(negedge clk);
        f_arrive = 1'b0;
        wait_grant(1, 6, cyc);
        f_sec_tick = 1'b0;
        check("t5 boundary latency", 32'(cyc),          1);
        check("t5 boundary wait",    32'(f_grant_wait), 1);

        apply_reset();
        f_arrive = 1'b1;
        @(negedge clk);
        f_arrive   = 1'b0;
        f_sec_tick = 1'b1;
        repeat (5) @(negedge clk);
        f_sec_tick = 1'b0;
        f_win_free = 2'b01;
        wait_grant(1, 6, cyc);
        check("t5 five minute wait", 32'(f_grant_wait), 5);

        apply_reset();
        f_arrive = 1'b1;
        @(negedge clk);
        f_arrive   = 1'b0;
        f_sec_tick = 1'b1;
        repeat (65540) @(negedge clk);
        f_sec_tick = 1'b0;
        f_win_free = 2'b01;
        wait_grant(1, 6, cyc);
        check("t5 saturated wait",   32'(f_grant_wait),   32'hFFFF);
        check("t5 saturated ticket", 32'(f_grant_ticket), 0);

        // ---------------- reset during HOLD ----------------
        apply_reset();
        arrive = 1'b1;
        repeat (5) @(negedge clk);
        arrive = 1'b0;
        check("t6 queued", 32'(queue_len), 5);
        win_free = 2'b01;
        wait_grant(0, 6, cyc);
        @(negedge clk);
        check("t6 hold queue_len", 32'(queue_len), 4);
        reset = 1'b0;
        #1;
        check("t6 reset queue_len",   32'(queue_len),   0);
        check("t6 reset grant_valid", 32'(grant_valid), 0);
        check("t6 reset full",        32'(full),        0);
        repeat (2) @(negedge clk);
        check("t6 in reset grant_valid", 32'(grant_valid), 0);
        reset    = 1'b1;
        win_free = 2'b11;
        @(negedge clk);
        arrive = 1'b1;
        @(negedge clk);
        arrive = 1'b0;
        check("t6 post accept", 32'(accept), 1);
        wait_grant(0, 6, cyc);
        check("t6 post ticket", 32'(grant_ticket), 0);
        check("t6 post rr win", 32'(grant_win),    0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
